// File: rtl/mole_detector_if.sv
// Signal bundle between the mole tracker and its neighbours: spawn/edge inputs in,
// LED mask, active count and hit/miss event pulses out.
interface mole_detector_if #(
  parameter int unsigned WIDTH = 18
);
  logic             spawn;
  logic [4:0]       spawn_idx;
  logic [WIDTH-1:0] edge_detect;
  logic [WIDTH-1:0] mole_mask;
  logic             hit_pulse;
  logic             miss_pulse;
  logic [4:0]       active_count;

  // Master drives spawn requests and switch edges; slave is the tracker itself.
  modport master (
    output spawn,
    output spawn_idx,
    output edge_detect,
    input  mole_mask,
    input  hit_pulse,
    input  miss_pulse,
    input  active_count
  );

  modport slave (
    input  spawn,
    input  spawn_idx,
    input  edge_detect,
    output mole_mask,
    output hit_pulse,
    output miss_pulse,
    output active_count
  );
endinterface

// File: rtl/mole_detector.sv
// Per-hole mole tracker: raises moles on spawn, ages them on prescaler ticks and turns
// switch edges into hit/miss events that are drained one pulse per cycle.
module mole_detector #(
  parameter int unsigned WIDTH       = 18,
  parameter int unsigned TICK_CYCLES = 50000000,
  parameter int unsigned LIFE_TICKS  = 3
) (
  input  logic           clk,
  input  logic           rst,
  mole_detector_if.slave bus
);

  localparam int unsigned PrescW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned PendMax = 63;
  // Wide enough for a full pending counter plus one event per hole.
  localparam int unsigned SumW    = $clog2(PendMax + WIDTH + 1);

  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_CYCLES - 1);
  localparam logic [3:0]        LifeInit  = 4'(LIFE_TICKS);
  localparam logic [SumW-1:0]   PendCap   = SumW'(PendMax);

  function automatic logic [SumW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [SumW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + SumW'(v[i]);
    end
    return cnt;
  endfunction

  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick;

  logic [WIDTH-1:0]  mole_mask_q, mole_mask_d;
  logic [3:0]        life_q [WIDTH];
  logic [3:0]        life_d [WIDTH];

  logic [5:0]        hit_pend_q, hit_pend_d;
  logic [5:0]        miss_pend_q, miss_pend_d;
  logic              hit_pulse_q, hit_pulse_d;
  logic              miss_pulse_q, miss_pulse_d;
  logic [4:0]        active_count_q, active_count_d;

  logic              spawn_ok;
  logic [WIDTH-1:0]  spawn_vec;
  logic [WIDTH-1:0]  hit_vec;
  logic [WIDTH-1:0]  miss_vec;
  logic [WIDTH-1:0]  escape_vec;

  logic [SumW-1:0]   hit_sum, miss_sum;
  logic [SumW-1:0]   hit_left, miss_left;

  // Lifetime prescaler.
  always_comb begin
    tick    = (presc_q == PrescLast);
    presc_d = tick ? '0 : presc_q + PrescW'(1);
  end

  // Per-hole evaluation against the mask registered at the start of the cycle.
  always_comb begin
    spawn_ok    = bus.spawn && (32'(bus.spawn_idx) < WIDTH);
    spawn_vec   = '0;
    hit_vec     = '0;
    miss_vec    = '0;
    escape_vec  = '0;
    mole_mask_d = '0;
    for (int j = 0; j < WIDTH; j++) begin
      life_d[j]     = life_q[j];
      spawn_vec[j]  = spawn_ok && (bus.spawn_idx == 5'(j)) && !mole_mask_q[j];
      hit_vec[j]    = bus.edge_detect[j] && mole_mask_q[j];
      miss_vec[j]   = bus.edge_detect[j] && !mole_mask_q[j];
      // A hit on the expiry tick wins; the edge suppresses the escape.
      escape_vec[j] = tick && mole_mask_q[j] && (life_q[j] == 4'd1) && !bus.edge_detect[j];
      mole_mask_d[j] = spawn_vec[j] || (mole_mask_q[j] && !hit_vec[j] && !escape_vec[j]);
      if (spawn_vec[j]) begin
        life_d[j] = LifeInit;
      end else if (tick && mole_mask_q[j] && (life_q[j] > 4'd1)) begin
        life_d[j] = life_q[j] - 4'd1;
      end
    end
  end

  // Event buffering: every event becomes exactly one pulse, one per cycle.
  always_comb begin
    hit_sum      = SumW'(hit_pend_q) + popcnt(hit_vec);
    miss_sum     = SumW'(miss_pend_q) + popcnt(miss_vec | escape_vec);
    hit_pulse_d  = (hit_sum != '0);
    miss_pulse_d = (miss_sum != '0);
    hit_left     = hit_sum - SumW'(hit_pulse_d);
    miss_left    = miss_sum - SumW'(miss_pulse_d);
    hit_pend_d   = (hit_left > PendCap) ? 6'(PendMax) : hit_left[5:0];
    miss_pend_d  = (miss_left > PendCap) ? 6'(PendMax) : miss_left[5:0];
    active_count_d = 5'(popcnt(mole_mask_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      mole_mask_q    <= '0;
      life_q         <= '{default: 4'd0};
      hit_pend_q     <= '0;
      miss_pend_q    <= '0;
      hit_pulse_q    <= 1'b0;
      miss_pulse_q   <= 1'b0;
      active_count_q <= '0;
    end else begin
      presc_q        <= presc_d;
      mole_mask_q    <= mole_mask_d;
      life_q         <= life_d;
      hit_pend_q     <= hit_pend_d;
      miss_pend_q    <= miss_pend_d;
      hit_pulse_q    <= hit_pulse_d;
      miss_pulse_q   <= miss_pulse_d;
      active_count_q <= active_count_d;
    end
  end

  assign bus.mole_mask    = mole_mask_q;
  assign bus.hit_pulse    = hit_pulse_q;
  assign bus.miss_pulse   = miss_pulse_q;
  assign bus.active_count = active_count_q;

endmodule

// File: tb/tb_mole_detector.sv
// Scoreboard bench for mole_detector: expected pulse edges are queued as stimulus is
// driven and matched against the pulses the DUT emits.
module tb_mole_detector;
  localparam int unsigned W = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mole_detector_if #(.WIDTH(W)) bus ();

  mole_detector #(
    .WIDTH      (W),
    .TICK_CYCLES(4),
    .LIFE_TICKS (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned edge_n  = 0;
  int unsigned rst_edge = 0;
  int unsigned exp_hit[$];
  int unsigned exp_miss[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Advance one clock, then match any pulse against the scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.hit_pulse === 1'b1) begin
      if (exp_hit.size() == 0) check_val("hit_spurious", 32'(bus.hit_pulse), 32'd0);
      else check_val("hit_edge", edge_n, exp_hit.pop_front());
    end
    if (bus.miss_pulse === 1'b1) begin
      if (exp_miss.size() == 0) check_val("miss_spurious", 32'(bus.miss_pulse), 32'd0);
      else check_val("miss_edge", edge_n, exp_miss.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst_edge = edge_n;
    rst = 1'b0;
  endtask

  task automatic spawn_at(input int unsigned idx);
    bus.spawn     = 1'b1;
    bus.spawn_idx = 5'(idx);
    step();
    bus.spawn     = 1'b0;
  endtask

  task automatic edges_at(input logic [W-1:0] m);
    bus.edge_detect = m;
    step();
    bus.edge_detect = '0;
  endtask

  task automatic drain(input int unsigned n);
    repeat (n) step();
    check_val("hit_queue_empty", exp_hit.size(), 32'd0);
    check_val("miss_queue_empty", exp_miss.size(), 32'd0);
  endtask

  // Edge at which a mole spawned at edge s escapes: third tick strictly after s.
  function automatic int unsigned expiry_edge(input int unsigned s);
    int unsigned first_tick;
    first_tick = s + 4 - ((s - rst_edge) % 4);
    return first_tick + 8;
  endfunction

  initial begin
    int unsigned e;
    int unsigned s;
    rst             = 1'b1;
    bus.spawn       = 1'b0;
    bus.spawn_idx   = '0;
    bus.edge_detect = '0;

    // Reset state
    do_reset();
    check_val("rst_mask", 32'(bus.mole_mask), 32'd0);
    check_val("rst_count", 32'(bus.active_count), 32'd0);
    check_val("rst_hit", 32'(bus.hit_pulse), 32'd0);
    check_val("rst_miss", 32'(bus.miss_pulse), 32'd0);

    // Single hit
    spawn_at(5);
    for (int i = 0; i < 3; i++) begin
      check_val("hit1_mask", 32'(bus.mole_mask), 32'h20);
      check_val("hit1_count", 32'(bus.active_count), 32'd1);
      if (i < 2) step();
    end
    exp_hit.push_back(edge_n + 1);
    edges_at(18'h00020);
    check_val("hit1_mask_clr", 32'(bus.mole_mask), 32'd0);
    check_val("hit1_count_clr", 32'(bus.active_count), 32'd0);
    drain(3);

    // Miss with no moles, then out-of-range spawn
    exp_miss.push_back(edge_n + 1);
    edges_at(18'h00080);
    check_val("miss_mask", 32'(bus.mole_mask), 32'd0);
    spawn_at(20);
    check_val("bad_spawn_mask", 32'(bus.mole_mask), 32'd0);
    check_val("bad_spawn_count", 32'(bus.active_count), 32'd0);
    drain(3);

    // Escape
    do_reset();
    step();
    spawn_at(2);
    s = edge_n;
    e = expiry_edge(s);
    exp_miss.push_back(e);
    while (edge_n < e + 2) begin
      check_val("esc_mask", 32'(bus.mole_mask), (edge_n < e) ? 32'h4 : 32'h0);
      step();
    end
    drain(2);

    // Burst of three hits in one cycle
    do_reset();
    spawn_at(0);
    spawn_at(1);
    spawn_at(2);
    check_val("burst_mask_up", 32'(bus.mole_mask), 32'h7);
    check_val("burst_count_up", 32'(bus.active_count), 32'd3);
    for (int i = 1; i <= 3; i++) exp_hit.push_back(edge_n + i);
    edges_at(18'h00007);
    check_val("burst_mask", 32'(bus.mole_mask), 32'd0);
    drain(5);

    // Hit on the same edge as the expiry tick
    do_reset();
    spawn_at(3);
    e = expiry_edge(edge_n);
    while (edge_n < e - 1) step();
    check_val("conf_a_mask_pre", 32'(bus.mole_mask), 32'h8);
    exp_hit.push_back(edge_n + 1);
    edges_at(18'h00008);
    check_val("conf_a_mask", 32'(bus.mole_mask), 32'd0);
    drain(4);

    // Respawn onto an active hole must not restart its timer
    do_reset();
    spawn_at(4);
    s = edge_n;
    e = expiry_edge(s);
    exp_miss.push_back(e);
    while (edge_n < s + 4) step();
    spawn_at(4);
    while (edge_n < e + 2) begin
      check_val("conf_b_mask", 32'(bus.mole_mask), (edge_n < e) ? 32'h10 : 32'h0);
      step();
    end
    drain(2);

    // Spawn plus edge on an inactive hole: miss, mole still raised
    do_reset();
    exp_miss.push_back(edge_n + 1);
    bus.edge_detect = 18'h00040;
    spawn_at(6);
    bus.edge_detect = '0;
    check_val("conf_c_mask", 32'(bus.mole_mask), 32'h40);
    check_val("conf_c_count", 32'(bus.active_count), 32'd1);
    // Spawn plus edge on the now-active hole: hit, spawn ignored
    exp_hit.push_back(edge_n + 1);
    bus.edge_detect = 18'h00040;
    spawn_at(6);
    bus.edge_detect = '0;
    check_val("conf_d_mask", 32'(bus.mole_mask), 32'd0);
    drain(3);

    // Reset in the middle of a five-hit burst
    do_reset();
    for (int i = 8; i < 13; i++) spawn_at(i);
    check_val("rstb_count_up", 32'(bus.active_count), 32'd5);
    exp_hit.push_back(edge_n + 1);
    exp_hit.push_back(edge_n + 2);
    edges_at(18'h01F00);
    step();
    do_reset();
    check_val("rstb_hit", 32'(bus.hit_pulse), 32'd0);
    check_val("rstb_miss", 32'(bus.miss_pulse), 32'd0);
    check_val("rstb_mask", 32'(bus.mole_mask), 32'd0);
    check_val("rstb_count", 32'(bus.active_count), 32'd0);
    drain(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
